// File: rtl/fifo_rf_2p_fwft_pkg.sv
// Shared defaults and control bundle for the first-word-fall-through FIFO built on rf_2p.
package fifo_rf_2p_fwft_pkg;

  localparam int FIFO_DEF_WORD_WIDTH = 256;
  localparam int FIFO_DEF_ADDR_WIDTH = 9;

  typedef struct packed {
    logic wr;
    logic issue;
    logic pop;
  } fifo_ctl_t;

endpackage

// File: rtl/fifo_rf_2p_fwft_rf_2p.sv
// Two-port register file: port A synchronous read (1-cycle latency), port B write; active-low enables.
module rf_2p #(
  parameter int Word_Width = 256,
  parameter int Addr_Width = 9
) (
  input  logic                  clka,
  input  logic                  cena_i,
  input  logic [Addr_Width-1:0] addra_i,
  output logic [Word_Width-1:0] dataa_o,
  input  logic                  clkb,
  input  logic                  cenb_i,
  input  logic                  wenb_i,
  input  logic [Addr_Width-1:0] addrb_i,
  input  logic [Word_Width-1:0] datab_i
);

  logic [Word_Width-1:0] mem [0:(1<<Addr_Width)-1];

  always_ff @(posedge clka) begin
    if (!cena_i) dataa_o <= mem[addra_i];
  end

  always_ff @(posedge clkb) begin
    if (!cenb_i && !wenb_i) mem[addrb_i] <= datab_i;
  end

endmodule

// File: rtl/fifo_rf_2p_fwft.sv
// FWFT FIFO over rf_2p with a one-entry output stage hiding the array read latency.
// Optional sticky overflow flag and check enabled by defining FIFO_RF_2P_ERR_EN.
module fifo_rf_2p_fwft
  import fifo_rf_2p_fwft_pkg::*;
#(
  parameter int WORD_WIDTH = FIFO_DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH = FIFO_DEF_ADDR_WIDTH,
  parameter int AFULL_TH   = (1 << ADDR_WIDTH) - 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  wr_val_i,
  output logic                  wr_rdy_o,
  input  logic [WORD_WIDTH-1:0] wr_dat_i,
  output logic                  rd_val_o,
  input  logic                  rd_rdy_i,
  output logic [WORD_WIDTH-1:0] rd_dat_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  afull_o
`ifdef FIFO_RF_2P_ERR_EN
  ,
  output logic                  ovf_o
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic [ADDR_WIDTH:0]   array_cnt;
  logic                  ram_out_valid;
  logic                  hold_valid;
  logic [WORD_WIDTH-1:0] hold_dat;
  logic [WORD_WIDTH-1:0] dataa;
  logic                  out_occ;
  fifo_ctl_t             ctl;

  // Handshake decode; flush masks every state-changing action
  always_comb begin
    ctl       = '0;
    out_occ   = hold_valid | ram_out_valid;
    ctl.pop   = out_occ & rd_rdy_i & ~flush_i;
    ctl.wr    = wr_val_i & wr_rdy_o & ~flush_i;
    ctl.issue = (array_cnt != '0) & (~out_occ | ctl.pop) & ~flush_i;
  end

  assign wr_rdy_o = (array_cnt != DEPTH);
  assign rd_val_o = out_occ;
  assign rd_dat_o = hold_valid ? hold_dat : (ram_out_valid ? dataa : '0);
  assign level_o  = array_cnt + {{ADDR_WIDTH{1'b0}}, out_occ};
  assign afull_o  = (int'(level_o) >= AFULL_TH);

  rf_2p #(
    .Word_Width (WORD_WIDTH),
    .Addr_Width (ADDR_WIDTH)
  ) u_rf (
    .clka    (clk),
    .cena_i  (~ctl.issue),
    .addra_i (rp),
    .dataa_o (dataa),
    .clkb    (clk),
    .cenb_i  (~ctl.wr),
    .wenb_i  (~ctl.wr),
    .addrb_i (wp),
    .datab_i (wr_dat_i)
  );

  // Pointer / count / output-stage state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp            <= '0;
      rp            <= '0;
      array_cnt     <= '0;
      ram_out_valid <= 1'b0;
      hold_valid    <= 1'b0;
      hold_dat      <= '0;
    end else if (flush_i) begin
      wp            <= '0;
      rp            <= '0;
      array_cnt     <= '0;
      ram_out_valid <= 1'b0;
      hold_valid    <= 1'b0;
    end else begin
      if (ctl.wr)    wp <= wp + 1'b1;
      if (ctl.issue) rp <= rp + 1'b1;
      case ({ctl.wr, ctl.issue})
        2'b10:   array_cnt <= array_cnt + 1'b1;
        2'b01:   array_cnt <= array_cnt - 1'b1;
        default: array_cnt <= array_cnt;
      endcase
      ram_out_valid <= ctl.issue;
      hold_valid    <= (ram_out_valid & ~ctl.pop) | (hold_valid & ~ctl.pop);
      // An unpopped array word must be parked before dataa is overwritten
      if (ram_out_valid && !ctl.pop) hold_dat <= dataa;
    end
  end

`ifdef FIFO_RF_2P_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ovf_o <= 1'b0;
    else if (flush_i)                ovf_o <= 1'b0;
    else if (wr_val_i && !wr_rdy_o)  ovf_o <= 1'b1;
  end

  ovf_chk: assert property (@(posedge clk) disable iff (!rst_n) !(wr_val_i && !wr_rdy_o))
    else $warning("fifo_rf_2p_fwft: write refused while full");
`endif

endmodule

// File: tb/tb_fifo_rf_2p_fwft.sv
// Scoreboard bench for fifo_rf_2p_fwft against a queue-based array+slot reference model.
module tb_fifo_rf_2p_fwft;
  localparam int WW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int AFTH  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i;
  logic          wr_val_i;
  logic          wr_rdy_o;
  logic [WW-1:0] wr_dat_i;
  logic          rd_val_o;
  logic          rd_rdy_i;
  logic [WW-1:0] rd_dat_o;
  logic [AW:0]   level_o;
  logic          afull_o;
`ifdef FIFO_RF_2P_ERR_EN
  logic          ovf_o;
`endif

  fifo_rf_2p_fwft #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .AFULL_TH(AFTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush_i),
    .wr_val_i (wr_val_i),
    .wr_rdy_o (wr_rdy_o),
    .wr_dat_i (wr_dat_i),
    .rd_val_o (rd_val_o),
    .rd_rdy_i (rd_rdy_i),
    .rd_dat_o (rd_dat_o),
    .level_o  (level_o),
    .afull_o  (afull_o)
`ifdef FIFO_RF_2P_ERR_EN
    ,
    .ovf_o    (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  // Reference model: array contents m_a, output slot m_s/m_sv, expected pop order exp_q
  logic [WW-1:0] m_a[$];
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] m_s;
  logic          m_sv;
  logic          m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    m_a.delete();
    exp_q.delete();
    m_sv  = 1'b0;
    m_s   = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic wv, input logic [WW-1:0] wd, input logic rr, input logic fl);
    bit pop, wr, iss;
    if (fl) begin
      model_clear();
    end else begin
      pop = m_sv && rr;
      wr  = wv && (m_a.size() != DEPTH);
      iss = (m_a.size() != 0) && (!m_sv || pop);
      if (wv && m_a.size() == DEPTH) m_ovf = 1'b1;
      if (pop) m_sv = 1'b0;
      if (iss) begin
        m_s  = m_a.pop_front();
        m_sv = 1'b1;
      end
      if (wr) begin
        m_a.push_back(wd);
        exp_q.push_back(wd);
      end
    end
  endtask

  task automatic check_model();
    int lvl;
    lvl = m_a.size() + int'(m_sv);
    chk("rd_val", 64'(rd_val_o), 64'(m_sv));
    chk("level", 64'(level_o), 64'(lvl));
    chk("wr_rdy", 64'(wr_rdy_o), 64'(m_a.size() != DEPTH));
    chk("afull", 64'(afull_o), 64'(lvl >= AFTH));
    if (m_sv) chk("rd_dat", 64'(rd_dat_o), 64'(m_s));
`ifdef FIFO_RF_2P_ERR_EN
    chk("ovf", 64'(ovf_o), 64'(m_ovf));
`endif
  endtask

  // Called at a negedge: check current state, drive next inputs, advance model
  task automatic step(input logic wv, input logic [WW-1:0] wd, input logic rr, input logic fl);
    check_model();
    wr_val_i = wv;
    wr_dat_i = wd;
    rd_rdy_i = rr;
    flush_i  = fl;
    model_step(wv, wd, rr, fl);
    @(negedge clk);
  endtask

  // Monitor: every accepted pop must match the front of the expected queue
  initial begin
    logic [WW-1:0] e;
    while (!done) begin
      @(negedge clk);
      #1;
      if (rst_n && !flush_i && rd_val_o && rd_rdy_i) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 64'(rd_dat_o), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", 64'(rd_dat_o), 64'(e));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, cyc;
    logic wv, rr;
    rst_n = 1'b0; flush_i = 1'b0; wr_val_i = 1'b0; rd_rdy_i = 1'b0; wr_dat_i = '0;
    model_clear();
    #1;
    chk("rst_rd_val", 64'(rd_val_o), 64'd0);
    chk("rst_rd_dat", 64'(rd_dat_o), 64'd0);
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_wr_rdy", 64'(wr_rdy_o), 64'd1);
    chk("rst_afull", 64'(afull_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single word latency
    step(1'b1, 32'hA5, 1'b0, 1'b0);
    chk("single_lvl_c1", 64'(level_o), 64'd1);
    chk("single_val_c1", 64'(rd_val_o), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("single_val_c2", 64'(rd_val_o), 64'd1);
    chk("single_dat_c2", 64'(rd_dat_o), 64'hA5);
    chk("single_lvl_c2", 64'(level_o), 64'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("single_val_pop", 64'(rd_val_o), 64'd0);
    chk("single_lvl_pop", 64'(level_o), 64'd0);

    // Fill with no reader: five words fit, sixth refused
    for (int i = 1; i <= 6; i++) step(1'b1, WW'(i), 1'b0, 1'b0);
    chk("fill_level", 64'(level_o), 64'd5);
    chk("fill_wr_rdy", 64'(wr_rdy_o), 64'd0);
`ifdef FIFO_RF_2P_ERR_EN
    chk("fill_ovf", 64'(ovf_o), 64'd1);
`endif
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);
    chk("fill_drained", 64'(level_o), 64'd0);

    // Streaming at full rate
    for (int i = 0; i < 100; i++) step(1'b1, WW'(i), 1'b1, 1'b0);
    chk("stream_level", 64'(level_o), 64'd2);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // Flush with three words queued and a read in flight
    for (int i = 1; i <= 4; i++) step(1'b1, WW'(32'h100 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'hDEAD, 1'b1, 1'b1);
    chk("flush_val", 64'(rd_val_o), 64'd0);
    chk("flush_level", 64'(level_o), 64'd0);
    step(1'b1, 32'h77, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("flush_first_dat", 64'(rd_dat_o), 64'h77);
    step(1'b0, '0, 1'b1, 1'b0);

    // Random backpressure
    nw = 0; cyc = 0;
    while (nw < 10000 && cyc < 60000) begin
      wv = ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 9) < 3);
      if (wv && m_a.size() != DEPTH) nw++;
      step(wv, $urandom, rr, 1'b0);
      cyc++;
    end
    chk("rand_words", 64'(nw), 64'd10000);
    repeat (10) step(1'b0, '0, 1'b1, 1'b0);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) step(1'b1, WW'(32'h200 + i), ($urandom_range(0, 1) == 1), 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_val", 64'(rd_val_o), 64'd0);
    chk("arst_rd_dat", 64'(rd_dat_o), 64'd0);
    chk("arst_level", 64'(level_o), 64'd0);
    chk("arst_wr_rdy", 64'(wr_rdy_o), 64'd1);
    wr_val_i = 1'b0; rd_rdy_i = 1'b0; flush_i = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, WW'(32'h300 + i), ($urandom_range(0, 1) == 1), 1'b0);
    repeat (12) step(1'b0, '0, 1'b1, 1'b0);
    chk("arst_drained", 64'(exp_q.size()), 64'd0);

    done = 1'b1;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
